// File: rtl/uart_cmd_responder.sv
`default_nettype none
// ============================================================================
// uart_cmd_responder : UART byte-stream to register-bus bridge ('W' a d / 'R' a)
// Rev 1.0 - initial release
// ============================================================================
module uart_cmd_responder #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 8,
    parameter int BYTE_TIMEOUT = 1000000,
    parameter int BUS_TIMEOUT  = 255,
    parameter int TO_WIDTH     = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_empty,
    output logic                  rx_read,
    output logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_full,
    output logic                  tx_write,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    output logic                  bus_we,
    output logic                  bus_re,
    input  logic [DATA_WIDTH-1:0] bus_rdata,
    input  logic                  bus_ack,
    output logic                  busy,
    output logic                  err_pulse
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_GET_ADDR = 3'd1,
        S_GET_DATA = 3'd2,
        S_BUS      = 3'd3,
        S_SEND     = 3'd4
    } state_t;

    localparam logic [DATA_WIDTH-1:0] c_OP_WRITE = DATA_WIDTH'(8'h57);
    localparam logic [DATA_WIDTH-1:0] c_OP_READ  = DATA_WIDTH'(8'h52);
    localparam logic [DATA_WIDTH-1:0] c_ACK      = DATA_WIDTH'(8'h06);
    localparam logic [DATA_WIDTH-1:0] c_NAK      = DATA_WIDTH'(8'h15);
    localparam logic [TO_WIDTH-1:0]   c_BYTE_LAST = TO_WIDTH'(BYTE_TIMEOUT - 1);
    localparam logic [TO_WIDTH-1:0]   c_BUS_LAST  = TO_WIDTH'(BUS_TIMEOUT - 1);

    state_t                r_state;
    logic                  r_is_write;
    logic                  r_pop_gap;
    logic                  r_push_gap;
    logic                  r_ack_pend;
    logic                  r_bus_we;
    logic                  r_bus_re;
    logic                  r_err;
    logic [TO_WIDTH-1:0]   r_byte_cnt;
    logic [TO_WIDTH-1:0]   r_bus_cnt;
    logic [DATA_WIDTH-1:0] r_tx_data;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata_hold;
    logic [ADDR_WIDTH-1:0] r_addr;

    logic                  w_rx_state;
    logic                  w_take;
    logic                  w_push;
    logic                  w_ack;
    logic [DATA_WIDTH-1:0] w_rdata;

    // Pop/push strobes are decoded from registered state so the FIFO acts on the
    // same edge the byte is latched; the gap flags cover the FIFO's lagging flags.
    assign w_rx_state = (r_state == S_IDLE) || (r_state == S_GET_ADDR) || (r_state == S_GET_DATA);
    assign w_take     = ce && !rx_empty && !r_pop_gap && w_rx_state;
    assign w_push     = ce && !tx_full && !r_push_gap && (r_state == S_SEND);
    assign w_ack      = bus_ack || r_ack_pend;
    assign w_rdata    = r_ack_pend ? r_rdata_hold : bus_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_is_write   <= 1'b0;
            r_pop_gap    <= 1'b0;
            r_push_gap   <= 1'b0;
            r_ack_pend   <= 1'b0;
            r_bus_we     <= 1'b0;
            r_bus_re     <= 1'b0;
            r_err        <= 1'b0;
            r_byte_cnt   <= '0;
            r_bus_cnt    <= '0;
            r_tx_data    <= '0;
            r_wdata      <= '0;
            r_rdata_hold <= '0;
            r_addr       <= '0;
        end else begin
            r_pop_gap  <= w_take;
            r_push_gap <= w_push;
            r_err      <= 1'b0;
            if (!ce) begin
                // An ack seen while stalled is kept, with its data, for the next enabled cycle.
                if ((r_state == S_BUS) && bus_ack && !r_ack_pend) begin
                    r_ack_pend   <= 1'b1;
                    r_rdata_hold <= bus_rdata;
                end
            end else begin
                r_ack_pend <= 1'b0;
                case (r_state)
                    S_IDLE: begin
                        if (w_take) begin
                            r_byte_cnt <= '0;
                            if ((rx_data == c_OP_WRITE) || (rx_data == c_OP_READ)) begin
                                r_is_write <= (rx_data == c_OP_WRITE);
                                r_state    <= S_GET_ADDR;
                            end else begin
                                r_tx_data <= c_NAK;
                                r_err     <= 1'b1;
                                r_state   <= S_SEND;
                            end
                        end
                    end
                    S_GET_ADDR, S_GET_DATA: begin
                        if (w_take) begin
                            r_byte_cnt <= '0;
                            r_bus_cnt  <= '0;
                            if (r_state == S_GET_ADDR) begin
                                r_addr <= rx_data[ADDR_WIDTH-1:0];
                                if (r_is_write) begin
                                    r_state <= S_GET_DATA;
                                end else begin
                                    r_bus_re <= 1'b1;
                                    r_state  <= S_BUS;
                                end
                            end else begin
                                r_wdata  <= rx_data;
                                r_bus_we <= 1'b1;
                                r_state  <= S_BUS;
                            end
                        end else if (r_byte_cnt == c_BYTE_LAST) begin
                            r_byte_cnt <= '0;
                            r_err      <= 1'b1;
                            r_state    <= S_IDLE;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + TO_WIDTH'(1);
                        end
                    end
                    S_BUS: begin
                        if (w_ack) begin
                            r_bus_we  <= 1'b0;
                            r_bus_re  <= 1'b0;
                            r_bus_cnt <= '0;
                            r_tx_data <= r_is_write ? c_ACK : w_rdata;
                            r_state   <= S_SEND;
                        end else if (r_bus_cnt == c_BUS_LAST) begin
                            r_bus_we  <= 1'b0;
                            r_bus_re  <= 1'b0;
                            r_bus_cnt <= '0;
                            r_tx_data <= c_NAK;
                            r_err     <= 1'b1;
                            r_state   <= S_SEND;
                        end else begin
                            r_bus_cnt <= r_bus_cnt + TO_WIDTH'(1);
                        end
                    end
                    S_SEND: begin
                        if (w_push) begin
                            r_state <= S_IDLE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign rx_read   = w_take;
    assign tx_write  = w_push;
    assign tx_data   = r_tx_data;
    assign bus_addr  = r_addr;
    assign bus_wdata = r_wdata;
    assign bus_we    = r_bus_we;
    assign bus_re    = r_bus_re;
    assign busy      = (r_state != S_IDLE);
    assign err_pulse = r_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_responder.sv
`default_nettype none
// ============================================================================
// tb_uart_cmd_responder : scoreboard bench with rx FIFO and bus responder models
// Rev 1.0 - initial release
// ============================================================================
module tb_uart_cmd_responder;

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
    } bus_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ce = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_empty = 1'b1;
    logic       rx_read;
    logic [7:0] tx_data;
    logic       tx_full = 1'b0;
    logic       tx_write;
    logic [7:0] bus_addr;
    logic [7:0] bus_wdata;
    logic       bus_we;
    logic       bus_re;
    logic [7:0] bus_rdata = 8'h00;
    logic       bus_ack = 1'b0;
    logic       busy;
    logic       err_pulse;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] rx_q[$];
    logic [7:0] exp_tx[$];
    bus_t       exp_bus[$];

    int   n_txw = 0, n_rxr = 0, n_err = 0, n_req = 0;
    int   s_txw, s_rxr, s_err, s_req;
    int   req_len = 0, last_req_len = 0, busy_len = 0;
    logic pop_req = 1'b0, req_s = 1'b0, prev_rx_read = 1'b0;
    bit   ce_mode = 1'b0, ack_en = 1'b1, acked = 1'b0;
    int   ack_delay = 0, ack_cnt = 0;

    always #5 clk = ~clk;

    uart_cmd_responder #(
        .DATA_WIDTH  (8),
        .ADDR_WIDTH  (8),
        .BYTE_TIMEOUT(50),
        .BUS_TIMEOUT (8),
        .TO_WIDTH    (20)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ce       (ce),
        .rx_data  (rx_data),
        .rx_empty (rx_empty),
        .rx_read  (rx_read),
        .tx_data  (tx_data),
        .tx_full  (tx_full),
        .tx_write (tx_write),
        .bus_addr (bus_addr),
        .bus_wdata(bus_wdata),
        .bus_we   (bus_we),
        .bus_re   (bus_re),
        .bus_rdata(bus_rdata),
        .bus_ack  (bus_ack),
        .busy     (busy),
        .err_pulse(err_pulse)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_rx(input logic [7:0] b);
        rx_q.push_back(b);
    endtask

    task automatic expect_bus(input logic we, input logic [7:0] addr, input logic [7:0] wdata);
        bus_t e;
        e.we = we;
        e.addr = addr;
        e.wdata = wdata;
        exp_bus.push_back(e);
    endtask

    task automatic snap();
        s_txw = n_txw;
        s_rxr = n_rxr;
        s_err = n_err;
        s_req = n_req;
        busy_len = 0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (rx_q.size() == 0 && !busy && exp_tx.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        chk(tag, 32'(ok), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    // Monitors sample mid-cycle; the scoreboard is drained here.
    always @(negedge clk) begin
        bus_t e;
        pop_req = rx_read;
        req_s   = bus_we | bus_re;
        if (rx_read) begin
            n_rxr++;
            chk("rx_gap", 32'(prev_rx_read), 32'd0);
            chk("rx_ce", 32'(ce), 32'd1);
        end
        prev_rx_read = rx_read;
        if (tx_write) begin
            n_txw++;
            chk("tx_ce", 32'(ce), 32'd1);
            if (exp_tx.size() == 0) chk("tx_unexpected", 32'd1, 32'd0);
            else chk("tx_data", 32'(tx_data), 32'(exp_tx.pop_front()));
        end
        if (err_pulse) n_err++;
        if (busy) busy_len++;
        if (bus_we | bus_re) begin
            if (req_len == 0) begin
                n_req++;
                chk("bus_excl", 32'(bus_we & bus_re), 32'd0);
                if (exp_bus.size() == 0) begin
                    chk("bus_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_bus.pop_front();
                    chk("bus_we", 32'(bus_we), 32'(e.we));
                    chk("bus_addr", 32'(bus_addr), 32'(e.addr));
                    if (e.we) chk("bus_wdata", 32'(bus_wdata), 32'(e.wdata));
                end
            end
            req_len++;
        end else if (req_len != 0) begin
            last_req_len = req_len;
            req_len = 0;
        end
    end

    // rx FIFO, ce pattern and bus responder all drive just after the active edge.
    always @(posedge clk) begin
        logic [7:0] dummy;
        #1;
        if (pop_req && rx_q.size() > 0) dummy = rx_q.pop_front();
        pop_req  = 1'b0;
        rx_empty = (rx_q.size() == 0);
        rx_data  = rx_empty ? 8'h00 : rx_q[0];
        ce       = ce_mode ? ~ce : 1'b1;
        if (!req_s) begin
            ack_cnt = 0;
            acked   = 1'b0;
            bus_ack = 1'b0;
        end else if (bus_ack) begin
            acked   = 1'b1;
            bus_ack = 1'b0;
        end else begin
            if (ack_en && !acked && ack_cnt == ack_delay) bus_ack = 1'b1;
            ack_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit seen;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_bus_addr", 32'(bus_addr), 32'd0);
        chk("rst_bus_wdata", 32'(bus_wdata), 32'd0);
        chk("rst_bus_req", 32'({bus_we, bus_re}), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err_pulse), 32'd0);
        chk("rst_strobes", 32'({rx_read, tx_write}), 32'd0);

        // Write with ack two cycles after the request rises
        snap();
        ack_en = 1'b1; ack_delay = 1;
        expect_bus(1'b1, 8'h10, 8'hA5);
        exp_tx.push_back(8'h06);
        @(posedge clk); #1;
        push_rx(8'h57); push_rx(8'h10); push_rx(8'hA5);
        wait_done("t1_done", 200);
        chk("t1_txw", 32'(n_txw - s_txw), 32'd1);
        chk("t1_rxr", 32'(n_rxr - s_rxr), 32'd3);
        chk("t1_req_len", 32'(last_req_len), 32'd3);
        chk("t1_err", 32'(n_err - s_err), 32'd0);

        // Read
        snap();
        ack_delay = 0; bus_rdata = 8'h3C;
        expect_bus(1'b0, 8'h22, 8'h00);
        exp_tx.push_back(8'h3C);
        @(posedge clk); #1;
        push_rx(8'h52); push_rx(8'h22);
        wait_done("t2_done", 200);
        chk("t2_txw", 32'(n_txw - s_txw), 32'd1);
        chk("t2_rxr", 32'(n_rxr - s_rxr), 32'd2);

        // Unknown opcode, then a normal read
        snap();
        exp_tx.push_back(8'h15);
        @(posedge clk); #1;
        push_rx(8'h41);
        wait_done("t3_done", 200);
        chk("t3_err", 32'(n_err - s_err), 32'd1);
        chk("t3_req", 32'(n_req - s_req), 32'd0);
        bus_rdata = 8'h5A;
        expect_bus(1'b0, 8'h01, 8'h00);
        exp_tx.push_back(8'h5A);
        @(posedge clk); #1;
        push_rx(8'h52); push_rx(8'h01);
        wait_done("t3b_done", 200);
        chk("t3_txw", 32'(n_txw - s_txw), 32'd2);

        // Byte timeout in GET_DATA
        snap();
        @(posedge clk); #1;
        push_rx(8'h57); push_rx(8'h10);
        wait_done("t4_done", 300);
        chk("t4_err", 32'(n_err - s_err), 32'd1);
        chk("t4_txw", 32'(n_txw - s_txw), 32'd0);
        chk("t4_req", 32'(n_req - s_req), 32'd0);
        chk("t4_busy_len", 32'(busy_len), 32'd52);

        // Bus timeout on a read
        snap();
        ack_en = 1'b0;
        expect_bus(1'b0, 8'h33, 8'h00);
        exp_tx.push_back(8'h15);
        @(posedge clk); #1;
        push_rx(8'h52); push_rx(8'h33);
        wait_done("t5_done", 200);
        chk("t5_req_len", 32'(last_req_len), 32'd8);
        chk("t5_err", 32'(n_err - s_err), 32'd1);
        chk("t5_txw", 32'(n_txw - s_txw), 32'd1);
        ack_en = 1'b1;

        // tx FIFO full stalls the response
        snap();
        @(posedge clk); #1;
        tx_full = 1'b1;
        exp_tx.push_back(8'h15);
        push_rx(8'h41);
        repeat (20) @(negedge clk);
        chk("t6_stall_txw", 32'(n_txw - s_txw), 32'd0);
        chk("t6_stall_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        tx_full = 1'b0;
        wait_done("t6_done", 100);
        chk("t6_txw", 32'(n_txw - s_txw), 32'd1);

        // Reset while the bus request is outstanding
        snap();
        ack_en = 1'b0;
        expect_bus(1'b1, 8'h44, 8'h55);
        @(posedge clk); #1;
        push_rx(8'h57); push_rx(8'h44); push_rx(8'h55);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus_we) begin
                seen = 1'b1;
                break;
            end
        end
        chk("t7_req_seen", 32'(seen), 32'd1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("t7_bus_req", 32'({bus_we, bus_re}), 32'd0);
        chk("t7_busy", 32'(busy), 32'd0);
        repeat (20) @(negedge clk);
        chk("t7_txw", 32'(n_txw - s_txw), 32'd0);
        ack_en = 1'b1;

        // Write with ce toggling every cycle
        snap();
        ce_mode = 1'b1; ack_delay = 1;
        expect_bus(1'b1, 8'h66, 8'h77);
        exp_tx.push_back(8'h06);
        @(posedge clk); #1;
        push_rx(8'h57); push_rx(8'h66); push_rx(8'h77);
        wait_done("t8_done", 400);
        chk("t8_txw", 32'(n_txw - s_txw), 32'd1);
        chk("t8_rxr", 32'(n_rxr - s_rxr), 32'd3);
        chk("t8_err", 32'(n_err - s_err), 32'd0);
        ce_mode = 1'b0;

        repeat (4) @(negedge clk);
        chk("exp_tx_left", 32'(exp_tx.size()), 32'd0);
        chk("exp_bus_left", 32'(exp_bus.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_cmd_responder.md
Name: uart_cmd_responder

Overview:
Byte-level command responder that sits on the host side of the uart block. It consumes received bytes from the uart rx FIFO, decodes a 3-byte write or 2-byte read command, and performs one transaction on a simple register bus. It then pushes a 1-byte response into the uart tx FIFO. This gives a UART-to-register bridge for debug and configuration access.

Parameters:
DATA_WIDTH, 8, width of UART words and bus data; must be 8.
ADDR_WIDTH, 8, bus address width; must be ≤ DATA_WIDTH; the address byte is truncated to ADDR_WIDTH.
BYTE_TIMEOUT, 1000000, max ce-qualified cycles between bytes of one command.
BUS_TIMEOUT, 255, max cycles waiting for bus_ack.
TO_WIDTH, 20, counter width; must hold max(BYTE_TIMEOUT, BUS_TIMEOUT).

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
ce  in  1  clock enable; all FSM/counter updates are qualified by ce
rx_data  in  DATA_WIDTH  head of uart rx FIFO (first-word fall-through)
rx_empty  in  1  rx FIFO empty
rx_read  out  1  one-cycle pulse that pops the rx FIFO
tx_data  out  DATA_WIDTH  response byte
tx_full  in  1  tx FIFO full
tx_write  out  1  one-cycle pulse that pushes tx_data
bus_addr  out  ADDR_WIDTH  transaction address
bus_wdata  out  DATA_WIDTH  write data
bus_we  out  1  write request level, held until ack or timeout
bus_re  out  1  read request level, held until ack or timeout
bus_rdata  in  DATA_WIDTH  read data, valid with bus_ack
bus_ack  in  1  transaction complete
busy  out  1  high in any state other than IDLE
err_pulse  out  1  one-cycle pulse on NAK or byte timeout

Behaviour:
- Reset: synchronous active-high reset forces state IDLE. rx_read=0, tx_write=0, bus_we=0, bus_re=0, busy=0, err_pulse=0, tx_data=0, bus_addr=0, bus_wdata=0, counters=0. Reset mid-transaction abandons it immediately; no response byte is sent.
- Protocol (bytes): 0x57 'W', addr, data → write → response 0x06 (ACK).
- 0x52 'R', addr → read → response = bus_rdata.
- Any other first byte → response 0x15 (NAK).
- Bus timeout → response 0x15 (NAK).
- Byte pop rule: a byte is taken when ce=1, rx_empty=0, and the pop-gap flag is clear.
  - Taking a byte latches rx_data and pulses rx_read for one cycle.
  - The pop-gap flag then masks rx_empty for the following cycle, because the FIFO flags lag by one cycle.
- Byte push rule: a byte is pushed when ce=1, tx_full=0, and the push-gap flag is clear. tx_write pulses for one cycle, then a one-cycle push gap applies.
- States:
  - IDLE: on a byte, go to GET_ADDR if W/R (remember the opcode). Otherwise latch NAK into tx_data and go to SEND.
  - GET_ADDR: on a byte, latch bus_addr. Go to GET_DATA if W, else BUS.
  - GET_DATA: on a byte, latch bus_wdata and go to BUS.
  - BUS: assert bus_we or bus_re (never both), starting the cycle after entry.
    - On bus_ack, drop the request in that same cycle. tx_data = 0x06 (W) or bus_rdata (R). Go to SEND.
    - If the bus counter reaches BUS_TIMEOUT first: drop the request, tx_data = 0x15, go to SEND.
    - bus_ack in IDLE or GET_* states is ignored.
  - SEND: wait for the push rule, pulse tx_write, then go to IDLE. A full tx FIFO stalls indefinitely; no timeout in SEND.
- Byte timeout: counter clears on each accepted byte and increments in GET_ADDR/GET_DATA while no byte is taken. When it reaches BYTE_TIMEOUT: go to IDLE, pulse err_pulse, send no response.
- err_pulse also pulses when a NAK is latched.
- ce=0: state, counters, and bus request levels hold; rx_read/tx_write stay low. bus_ack arriving while ce=0 is registered and honoured on the next ce=1 cycle.
- Throughput: at most one rx pop per 2 cycles. Minimum command-to-response latency for a write: 3 pops + 1 bus cycle with immediate ack + 1 push.

Test Plan:
- rx bytes 57,10,A5; bus_ack 2 cycles after bus_we → bus_addr=0x10, bus_wdata=0xA5, bus_we high exactly until ack; tx_write once with tx_data=0x06; 3 rx_read pulses, never on consecutive cycles.
- rx bytes 52,22; bus_rdata=0x3C with ack → bus_re only; tx_data=0x3C pushed once.
- rx byte 41 → tx_data=0x15 pushed; err_pulse once; next command 52,01 decodes normally.
- rx 57,10 then silence, with BYTE_TIMEOUT=50 → after 50 cycles: IDLE, err_pulse, no tx_write, no bus_we.
- Read with bus_ack never asserted, BUS_TIMEOUT=8 → bus_re drops after 8 cycles; 0x15 pushed.
- Response pending with tx_full=1 for 20 cycles → no tx_write until tx_full falls, then exactly one.
- Reset asserted in BUS → bus_we/bus_re low next cycle, busy=0, no response.
- ce toggled 50% during a write → same results, just stretched.
